// File: rtl/rst_sequencer.sv
// ---------------------------------------------------------------------------
// rst_sequencer
//
// Turns the generator's clock/reset into NUM_STAGES staged per-subsystem
// resets. Stage 0 is released first. Each later stage is released only
// after the previous stage has acknowledged and a hold time has passed.
// Loss of PLL lock or a soft-reset request asserts every stage again.
//
// Optional feature: define RST_SEQ_ACK_TMO_EN to enable the ack timeout.
// With it, a stage that does not acknowledge within ACK_TMO cycles puts the
// block into FAULT and raises ERR_O. Without it, the block waits for the
// ack indefinitely and ERR_O stays 0.
//
// Ports
//   CLK          in   system clock
//   RST          in   asynchronous active-high reset
//   LOCKED_I     in   PLL locked (async, synchronised here)
//   SOFT_RST_I   in   soft-reset request level (async, rising edge used)
//   STAGE_ACK_I  in   per-stage ready/alive acknowledge
//   STAGE_RST_O  out  per-stage active-high reset, released in order 0..N-1
//   ALL_RDY_O    out  every stage released and acknowledged
//   BUSY_O       out  sequencing in progress (not RUN, not FAULT)
//   ERR_O        out  ack timeout flag
// ---------------------------------------------------------------------------
module rst_sequencer #(
   parameter int NUM_STAGES = 4,
   parameter int STAGE_WAIT = 16,
   parameter int SYNC_DEPTH = 2,
   parameter int ACK_TMO    = 255
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  LOCKED_I,
   input  logic                  SOFT_RST_I,
   input  logic [NUM_STAGES-1:0] STAGE_ACK_I,
   output logic [NUM_STAGES-1:0] STAGE_RST_O,
   output logic                  ALL_RDY_O,
   output logic                  BUSY_O,
   output logic                  ERR_O
);

   localparam int CNT_MAX = (STAGE_WAIT > ACK_TMO) ? STAGE_WAIT : ACK_TMO;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(STAGE_WAIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);
`ifdef RST_SEQ_ACK_TMO_EN
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(ACK_TMO - 1);
`endif

   typedef enum logic [2:0] {
      WAIT_LOCK,
      HOLD,
      WAIT_ACK,
      RUN,
      FAULT
   } state_t;

   state_t                state_reg, state_next;
   logic [IDX_W-1:0]      idx_reg, idx_next;
   logic [CNT_W-1:0]      cnt_reg, cnt_next;
   logic [NUM_STAGES-1:0] stage_rst_reg, stage_rst_next;
   logic                  all_rdy_reg, all_rdy_next;
   logic                  busy_reg, busy_next;
   logic                  err_reg, err_next;

   logic [SYNC_DEPTH-1:0] lock_sync_reg;
   logic [SYNC_DEPTH-1:0] soft_sync_reg;
   logic                  soft_prev_reg;
   logic                  lk;
   logic                  sr;

   // Input synchronisers; soft_prev_reg turns the synced level into a
   // single-cycle rising-edge strobe so a held request restarts only once.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         lock_sync_reg <= '0;
         soft_sync_reg <= '0;
         soft_prev_reg <= 1'b0;
      end else begin
         lock_sync_reg <= {lock_sync_reg[SYNC_DEPTH-2:0], LOCKED_I};
         soft_sync_reg <= {soft_sync_reg[SYNC_DEPTH-2:0], SOFT_RST_I};
         soft_prev_reg <= soft_sync_reg[SYNC_DEPTH-1];
      end
   end

   assign lk = lock_sync_reg[SYNC_DEPTH-1];
   assign sr = soft_sync_reg[SYNC_DEPTH-1] & ~soft_prev_reg;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg     <= WAIT_LOCK;
         idx_reg       <= '0;
         cnt_reg       <= '0;
         stage_rst_reg <= '1;
         all_rdy_reg   <= 1'b0;
         busy_reg      <= 1'b1;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         cnt_reg       <= cnt_next;
         stage_rst_reg <= stage_rst_next;
         all_rdy_reg   <= all_rdy_next;
         busy_reg      <= busy_next;
         err_reg       <= err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      idx_next       = idx_reg;
      cnt_next       = cnt_reg;
      stage_rst_next = stage_rst_reg;
      err_next       = err_reg;

      if (!lk) begin
         state_next     = WAIT_LOCK;
         idx_next       = '0;
         cnt_next       = '0;
         stage_rst_next = '1;
         err_next       = 1'b0;
      end else if (sr) begin
         // Lock is already good, so restart straight into the first hold.
         state_next     = HOLD;
         idx_next       = '0;
         cnt_next       = '0;
         stage_rst_next = '1;
         err_next       = 1'b0;
      end else begin
         case (state_reg)
            WAIT_LOCK: begin
               // lk is known to be 1 here; the branch above handles lk=0.
               state_next     = HOLD;
               idx_next       = '0;
               cnt_next       = '0;
               stage_rst_next = '1;
            end
            HOLD: begin
               // Holding for STAGE_WAIT cycles, releasing on the last one.
               if (cnt_reg >= HOLD_LAST) begin
                  stage_rst_next[idx_reg] = 1'b0;
                  cnt_next                = '0;
                  state_next              = WAIT_ACK;
               end else begin
                  cnt_next = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;
               end
            end
            WAIT_ACK: begin
               if (STAGE_ACK_I[idx_reg]) begin
                  cnt_next = '0;
                  if (idx_reg == IDX_LAST) begin
                     state_next = RUN;
                  end else begin
                     idx_next   = idx_reg + 1'b1;
                     state_next = HOLD;
                  end
               end
`ifdef RST_SEQ_ACK_TMO_EN
               else if (cnt_reg >= TMO_LAST) begin
                  // A silent stage is put back into reset with everything
                  // after it; earlier stages keep running.
                  stage_rst_next[idx_reg] = 1'b1;
                  err_next                = 1'b1;
                  state_next              = FAULT;
               end else begin
                  cnt_next = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;
               end
`endif
            end
            RUN:     state_next = RUN;
            FAULT:   state_next = FAULT;
            default: state_next = WAIT_LOCK;
         endcase
      end

      all_rdy_next = (state_next == RUN);
      busy_next    = (state_next != RUN) && (state_next != FAULT);
   end

   assign STAGE_RST_O = stage_rst_reg;
   assign ALL_RDY_O   = all_rdy_reg;
   assign BUSY_O      = busy_reg;
   assign ERR_O       = err_reg;

endmodule

// File: tb/tb_rst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rst_sequencer
//
// Self-checking bench for rst_sequencer (NUM_STAGES=4, STAGE_WAIT=16,
// SYNC_DEPTH=2, ACK_TMO=255). Expected output changes are pushed into a
// queue when stimulus is applied; a negedge monitor pops one entry for every
// observed change of {STAGE_RST_O, ALL_RDY_O, BUSY_O, ERR_O} and checks
// both the value and the cycle distance from the previous change (or from
// the stimulus that caused it). Any change with nothing queued is an error.
// The timeout scenario is exercised when RST_SEQ_ACK_TMO_EN is defined.
// ---------------------------------------------------------------------------
module tb_rst_sequencer;

   logic       CLK;
   logic       RST;
   logic       LOCKED_I;
   logic       SOFT_RST_I;
   logic [3:0] STAGE_ACK_I;
   logic [3:0] STAGE_RST_O;
   logic       ALL_RDY_O;
   logic       BUSY_O;
   logic       ERR_O;

   rst_sequencer #(
      .NUM_STAGES (4),
      .STAGE_WAIT (16),
      .SYNC_DEPTH (2),
      .ACK_TMO    (255)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .LOCKED_I    (LOCKED_I),
      .SOFT_RST_I  (SOFT_RST_I),
      .STAGE_ACK_I (STAGE_ACK_I),
      .STAGE_RST_O (STAGE_RST_O),
      .ALL_RDY_O   (ALL_RDY_O),
      .BUSY_O      (BUSY_O),
      .ERR_O       (ERR_O)
   );

   // One step of the standard release sequence: ack inputs to apply and the
   // output change expected next, with its distance from the previous change.
   typedef struct {
      logic [3:0] ack;
      logic [3:0] rst;
      logic       rdy;
      logic       busy;
      logic       err;
      int         dmin;
      int         dmax;
   } vec_t;

   typedef struct {
      logic [6:0] val;
      int         dmin;
      int         dmax;
   } exp_t;

   vec_t       tbl [5];
   exp_t       exp_q [$];
   int         cyc = 0;
   int         ref_cyc = 0;
   int         n_total = 0;
   int         n_pass = 0;
   logic [6:0] prev_obs;
   logic [6:0] cur_obs;
   exp_t       cur_exp;
   bit         mon_en = 0;
   string      cur_test = "reset";

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s [%s]: got 0x%0h required 0x%0h", name, cur_test, act, exp);
   endtask

   task automatic check_rng(input string name, input int act, input int lo, input int hi);
      n_total++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s [%s]: got %0d cycles required %0d..%0d", name, cur_test, act, lo, hi);
   endtask

   // Monitor: one line and one scoreboard pop per observed output change.
   always @(negedge CLK) begin
      cur_obs = {STAGE_RST_O, ALL_RDY_O, BUSY_O, ERR_O};
      if (mon_en && cur_obs !== prev_obs) begin
         $display("event [%s] cyc=%0d dt=%0d stage_rst=%b all_rdy=%b busy=%b err=%b",
                  cur_test, cyc, cyc - ref_cyc, STAGE_RST_O, ALL_RDY_O, BUSY_O, ERR_O);
         if (exp_q.size() == 0) begin
            check("unexpected_change", 32'(cur_obs), 32'(prev_obs));
         end else begin
            cur_exp = exp_q.pop_front();
            check("outputs", 32'(cur_obs), 32'(cur_exp.val));
            check_rng("delay", cyc - ref_cyc, cur_exp.dmin, cur_exp.dmax);
         end
         ref_cyc = cyc;
      end
      prev_obs = cur_obs;
   end

   task automatic push_exp(input logic [3:0] rst, input logic rdy, input logic busy,
                           input logic err, input int dmin, input int dmax);
      exp_t e;
      e.val  = {rst, rdy, busy, err};
      e.dmin = dmin;
      e.dmax = dmax;
      exp_q.push_back(e);
   endtask

   // Wait (bounded) until the monitor has consumed every queued expectation.
   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge CLK);
         #2;
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   // Apply table rows [first, first+count); the first row's delay window is
   // supplied by the caller since it depends on what started the sequence.
   task automatic run_seq(input int first, input int count, input int fmin,
                          input int fmax, input logic [3:0] mask);
      for (int i = first; i < first + count; i++) begin
         STAGE_ACK_I = tbl[i].ack & mask;
         push_exp(tbl[i].rst, tbl[i].rdy, tbl[i].busy, tbl[i].err,
                  (i == first) ? fmin : tbl[i].dmin,
                  (i == first) ? fmax : tbl[i].dmax);
         wait_drain(400);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, %0d/%0d so far", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   initial begin
      RST         = 1'b1;
      LOCKED_I    = 1'b0;
      SOFT_RST_I  = 1'b0;
      STAGE_ACK_I = 4'b1111;

      tbl[0] = '{4'b1111, 4'b1110, 1'b0, 1'b1, 1'b0, 17, 17};
      tbl[1] = '{4'b1111, 4'b1100, 1'b0, 1'b1, 1'b0, 17, 17};
      tbl[2] = '{4'b1111, 4'b1000, 1'b0, 1'b1, 1'b0, 17, 17};
      tbl[3] = '{4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 17, 17};
      tbl[4] = '{4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0,  1,  1};

      // Reset values, then no release while lock is absent.
      tick(5);
      check("rst_stage_rst", 32'(STAGE_RST_O), 32'h0000_000f);
      check("rst_all_rdy", 32'(ALL_RDY_O), 32'd0);
      check("rst_busy", 32'(BUSY_O), 32'd1);
      check("rst_err", 32'(ERR_O), 32'd0);
      cur_test = "no_lock";
      RST    = 1'b0;
      mon_en = 1'b1;
      tick(8);
      check("nolock_stage_rst", 32'(STAGE_RST_O), 32'h0000_000f);

      // Lock arrives: sync + WAIT_LOCK + 16-cycle hold before stage 0.
      cur_test = "first_sequence";
      LOCKED_I = 1'b1;
      ref_cyc  = cyc;
      run_seq(0, 5, 18, 20, 4'b1111);

      // Acks dropping after release must not disturb RUN.
      cur_test = "ack_drop_in_run";
      STAGE_ACK_I = 4'b0000;
      tick(20);
      check("run_all_rdy", 32'(ALL_RDY_O), 32'd1);
      check("run_stage_rst", 32'(STAGE_RST_O), 32'd0);
      STAGE_ACK_I = 4'b1111;

      // One-cycle lock loss in RUN: everything re-asserts, full restart.
      cur_test = "lock_loss";
      LOCKED_I = 1'b0;
      ref_cyc  = cyc;
      push_exp(4'b1111, 1'b0, 1'b1, 1'b0, 1, 3);
      tick(1);
      LOCKED_I = 1'b1;
      wait_drain(20);
      run_seq(0, 5, 17, 17, 4'b1111);

      // Soft reset (held high) with ack[2] missing: stall after stage 2.
      cur_test = "soft_stall";
      SOFT_RST_I  = 1'b1;
      STAGE_ACK_I = 4'b1011;
      ref_cyc     = cyc;
      push_exp(4'b1111, 1'b0, 1'b1, 1'b0, 1, 3);
      wait_drain(20);
      run_seq(0, 3, 16, 16, 4'b1011);
      SOFT_RST_I = 1'b0;
      tick(40);
      check("stall_stage_rst", 32'(STAGE_RST_O), 32'h0000_0008);
      check("stall_busy", 32'(BUSY_O), 32'd1);
      check("stall_all_rdy", 32'(ALL_RDY_O), 32'd0);
      STAGE_ACK_I = 4'b1111;
      ref_cyc     = cyc;
      run_seq(3, 2, 17, 17, 4'b1111);

      // Reset asserted during the stage-2 hold acts without a clock edge.
      cur_test = "rst_mid_hold";
      SOFT_RST_I = 1'b1;
      ref_cyc    = cyc;
      push_exp(4'b1111, 1'b0, 1'b1, 1'b0, 1, 3);
      wait_drain(20);
      run_seq(0, 2, 16, 16, 4'b1111);
      SOFT_RST_I = 1'b0;
      tick(5);
      push_exp(4'b1111, 1'b0, 1'b1, 1'b0, 0, 0);
      ref_cyc = cyc;
      RST     = 1'b1;
      #1;
      check("async_stage_rst", 32'(STAGE_RST_O), 32'h0000_000f);
      check("async_busy", 32'(BUSY_O), 32'd1);
      wait_drain(20);
      tick(3);
      cur_test = "after_rst";
      RST     = 1'b0;
      ref_cyc = cyc;
      run_seq(0, 5, 18, 20, 4'b1111);

`ifdef RST_SEQ_ACK_TMO_EN
      // Stage 1 never acknowledges: timeout, FAULT, then soft-reset recovery.
      cur_test = "ack_timeout";
      SOFT_RST_I = 1'b1;
      ref_cyc    = cyc;
      push_exp(4'b1111, 1'b0, 1'b1, 1'b0, 1, 3);
      wait_drain(20);
      run_seq(0, 2, 16, 16, 4'b1101);
      SOFT_RST_I = 1'b0;
      push_exp(4'b1110, 1'b0, 1'b0, 1'b1, 255, 255);
      wait_drain(400);
      check("fault_err", 32'(ERR_O), 32'd1);
      check("fault_busy", 32'(BUSY_O), 32'd0);
      cur_test = "fault_recover";
      STAGE_ACK_I = 4'b1111;
      SOFT_RST_I  = 1'b1;
      ref_cyc     = cyc;
      push_exp(4'b1111, 1'b0, 1'b1, 1'b0, 1, 3);
      wait_drain(20);
      run_seq(0, 5, 16, 16, 4'b1111);
      SOFT_RST_I = 1'b0;
`endif

      tick(5);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
